// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive (and later transmit) path.
package ps2_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} ps2_state_e;

  localparam int ST_PAR = 0;
  localparam int ST_FRM = 1;
  localparam int ST_OVF = 2;
  localparam int ST_TMO = 3;

  localparam int   DATA_BITS = 8;
  localparam logic START     = 1'b0;
  localparam logic STOP      = 1'b1;
endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous show-ahead FIFO; dout_o always presents the head entry.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_q, rd_q;
  logic [AW:0]                 cnt_q;
  logic                        do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_q];
  assign level_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/ps2_rx_ctrl.sv
// System-clock PS/2 receiver: sync + glitch filter, frame FSM, byte FIFO.
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk_i,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_data_i,
  input  logic                          rd_i,
  input  logic                          err_clr_i,
  output logic [7:0]                    data_o,
  output logic                          rx_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic [3:0]                    status_o
);
  localparam int FCW = $clog2(FILTER_LEN);
  localparam logic [FCW-1:0] FRELOAD = FCW'(FILTER_LEN - 1);

  if (FILTER_LEN < 2) begin : g_bad_filter
    $error("FILTER_LEN must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be >= 2");
  end

  // Index 0 is the PS/2 clock line, index 1 the data line.
  logic [1:0]          sync1_q, sync2_q, filt_q;
  logic [1:0][FCW-1:0] fcnt_q;
  logic                clk_prev_q;
  logic                fall, bit_in;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      filt_q     <= '1;
      fcnt_q     <= {2{FRELOAD}};
      clk_prev_q <= 1'b1;
    end else begin
      sync1_q    <= {ps2_data_i, ps2_clk_i};
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= FRELOAD;
        end else if (fcnt_q[i] == '0) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= FRELOAD;
        end else begin
          fcnt_q[i] <= fcnt_q[i] - FCW'(1);
        end
      end
    end
  end

  assign fall   = clk_prev_q & ~filt_q[0];
  assign bit_in = filt_q[1];

  ps2_state_e state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] sr_q, sr_d;
  logic       pend_q, pend_d;
  logic       push_q, push_d;
  logic [3:0] status_q, status_d, set;
  logic       fifo_full, fifo_empty, tmo_hit;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TRELOAD = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q != S_IDLE) && !fall && (tmo_q == '0);

  always_comb begin
    tmo_d = tmo_q;
    if (fall || state_q == S_IDLE) tmo_d = TRELOAD;
    else if (tmo_q != '0)          tmo_d = tmo_q - TW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst) tmo_q <= TRELOAD;
    else     tmo_q <= tmo_d;
  end
`else
  // No watchdog: a stalled frame holds until en drops or rst.
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    pend_d   = pend_q;
    push_d   = 1'b0;
    set      = '0;
    case (state_q)
      S_IDLE: if (fall && bit_in == START) begin
        state_d  = S_DATA;
        bitcnt_d = '0;
        pend_d   = 1'b0;
      end
      S_DATA: if (fall) begin
        sr_d     = {bit_in, sr_q[7:1]};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = S_PARITY;
      end
      S_PARITY: if (fall) begin
        // Odd parity: data plus parity bit must hold an odd number of ones.
        pend_d  = ~^{sr_q, bit_in};
        state_d = S_STOP;
      end
      S_STOP: if (fall) begin
        if (bit_in != STOP) set[ST_FRM] = 1'b1;
        else if (pend_q)    set[ST_PAR] = 1'b1;
        push_d  = (bit_in == STOP) && !pend_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d     = S_IDLE;
      set[ST_TMO] = 1'b1;
    end
    if (!en) begin
      state_d = S_IDLE;
      push_d  = 1'b0;
      set     = '0;
    end
    set[ST_OVF] = push_q & fifo_full & ~rd_i;
    status_d    = (err_clr_i ? 4'b0000 : status_q) | set;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      sr_q     <= '0;
      pend_q   <= 1'b0;
      push_q   <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      pend_q   <= pend_d;
      push_q   <= push_d;
      status_q <= status_d;
    end
  end

  ps2_rx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst     (rst),
    .push_i  (push_q),
    .pop_i   (rd_i),
    .din_i   (sr_q),
    .dout_o  (data_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (level_o)
  );

  assign rx_valid_o = ~fifo_empty;
  assign busy_o     = (state_q != S_IDLE);
  assign status_o   = status_q;
endmodule
